// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - controller state encodings and default timing constants shared by the traffic blocks
package traffic_pkg;

    typedef enum logic [1:0] {
        ST_MG = 2'd0,
        ST_MY = 2'd1,
        ST_CG = 2'd2,
        ST_CY = 2'd3
    } tl_state_t;

    localparam int DEB_CYC_DEF = 1_000_000;
    localparam int SEC_CYC_DEF = 50_000_000;

endpackage

// File: rtl/vehicle_detect_if.sv
// rtl/vehicle_detect_if.sv - sensor/state inputs and request/count outputs of the vehicle detector
interface vehicle_detect_if #(
    parameter int CNT_W = 8
);
    logic             sensor;
    logic [1:0]       state;
    logic             S;
    logic [CNT_W-1:0] car_cnt;
    logic             sensor_db;
    logic             evt;

    modport master (
        output sensor, state,
        input  S, car_cnt, sensor_db, evt
    );

    modport slave (
        input  sensor, state,
        output S, car_cnt, sensor_db, evt
    );
endinterface

// File: rtl/sensor_debounce.sv
// rtl/sensor_debounce.sv - 2-flop synchroniser, stability debounce and accepted-rise pulse
module sensor_debounce
    import traffic_pkg::*;
#(
    parameter int DEB_CYC = DEB_CYC_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise
);
    localparam int DW = $clog2(DEB_CYC + 1);

    logic          sync1;
    logic          sync2;
    logic          level_d;
    logic [DW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            cnt     <= '0;
            level   <= 1'b0;
            level_d <= 1'b0;
            rise    <= 1'b0;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            // Any sample agreeing with the accepted level restarts the stability window
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == DW'(DEB_CYC - 1)) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + DW'(1);
            end
            level_d <= level;
            rise    <= level & ~level_d;
        end
    end
endmodule

// File: rtl/vehicle_detect.sv
// rtl/vehicle_detect.sv - country-road vehicle counter and service request S
// Optional wait timeout forcing S after MAX_WAIT seconds: VD_WAIT_TIMEOUT_EN
module vehicle_detect
    import traffic_pkg::*;
#(
    parameter int DEB_CYC  = DEB_CYC_DEF,
    parameter int THRESH   = 1,
    parameter int CNT_W    = 8
`ifdef VD_WAIT_TIMEOUT_EN
    ,
    parameter int SEC_CYC  = SEC_CYC_DEF,
    parameter int MAX_WAIT = 30
`endif
) (
    input  logic             clk,
    input  logic             rst,
    vehicle_detect_if.slave  bus
);
    localparam logic [CNT_W:0] THRESH_V = (CNT_W + 1)'(THRESH);

    tl_state_t        st;
    logic             in_cg;
    logic             evt;
    logic             sensor_db;
    logic [CNT_W-1:0] cnt_q;
    logic             s_q;
    logic             s_next;

    assign st    = tl_state_t'(bus.state);
    assign in_cg = (st == ST_CG);

    sensor_debounce #(.DEB_CYC(DEB_CYC)) u_deb (
        .clk   (clk),
        .rst   (rst),
        .raw   (bus.sensor),
        .level (sensor_db),
        .rise  (evt)
    );

    // During country-green a detected pulse is a departing vehicle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (evt) begin
            if (in_cg) begin
                if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
            end else begin
                if (cnt_q != {CNT_W{1'b1}}) cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

`ifdef VD_WAIT_TIMEOUT_EN
    localparam int PW = $clog2(SEC_CYC + 1);
    localparam int WW = $clog2(MAX_WAIT + 1);

    logic [PW-1:0] presc;
    logic [WW-1:0] wait_sec;
    logic          timeout;

    assign timeout = (wait_sec == WW'(MAX_WAIT));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc    <= '0;
            wait_sec <= '0;
        end else if (in_cg || cnt_q == '0) begin
            presc    <= '0;
            wait_sec <= '0;
        end else if (!timeout) begin
            if (presc == PW'(SEC_CYC - 1)) begin
                presc    <= '0;
                wait_sec <= wait_sec + WW'(1);
            end else begin
                presc <= presc + PW'(1);
            end
        end
    end
`endif

    always_comb begin
        s_next = 1'b0;
        if (in_cg) begin
            s_next = (cnt_q != '0);
        end else begin
            s_next = ({1'b0, cnt_q} >= THRESH_V);
`ifdef VD_WAIT_TIMEOUT_EN
            s_next = s_next | timeout;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) s_q <= 1'b0;
        else      s_q <= s_next;
    end

    assign bus.S         = s_q;
    assign bus.car_cnt   = cnt_q;
    assign bus.sensor_db = sensor_db;
    assign bus.evt       = evt;
endmodule

// File: tb/tb_vehicle_detect.sv
// tb/tb_vehicle_detect.sv - directed bench with sample-history reference model for vehicle_detect
module tb_vehicle_detect;
    localparam int DEB = 4;
    localparam int SEC = 10;
    localparam int MW  = 3;
    localparam int TH  = 2;
`ifdef VD_WAIT_TIMEOUT_EN
    localparam bit TMO = 1'b1;
`else
    localparam bit TMO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sensor = 1'b0;
    logic [1:0] state = 2'd0;

    always #5 clk = ~clk;

    vehicle_detect_if #(.CNT_W(8)) ifa ();
    vehicle_detect_if #(.CNT_W(2)) ifb ();

    assign ifa.sensor = sensor;
    assign ifa.state  = state;
    assign ifb.sensor = sensor;
    assign ifb.state  = state;

    vehicle_detect #(.DEB_CYC(DEB), .THRESH(TH), .CNT_W(8)
`ifdef VD_WAIT_TIMEOUT_EN
        , .SEC_CYC(SEC), .MAX_WAIT(MW)
`endif
    ) dut_a (.clk(clk), .rst(rst), .bus(ifa));

    vehicle_detect #(.DEB_CYC(DEB), .THRESH(TH), .CNT_W(2)
`ifdef VD_WAIT_TIMEOUT_EN
        , .SEC_CYC(SEC), .MAX_WAIT(MW)
`endif
    ) dut_b (.clk(clk), .rst(rst), .bus(ifb));

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: hist[i] is the sensor level sampled i+1 edges ago
    bit hist [0:DEB];
    bit m_db   = 1'b0;
    bit m_rose = 1'b0;
    bit m_evt  = 1'b0;
    int m_cnt  [2] = '{0, 0};
    bit m_s    [2] = '{1'b0, 1'b0};
    int m_wait [2] = '{0, 0};
    int cmax   [2] = '{255, 3};

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i <= DEB; i++) hist[i] = 1'b0;
            m_db = 1'b0; m_rose = 1'b0; m_evt = 1'b0;
            for (int d = 0; d < 2; d++) begin
                m_cnt[d] = 0; m_s[d] = 1'b0; m_wait[d] = 0;
            end
        end else begin
            bit all_diff;
            bit new_db;
            all_diff = 1'b1;
            for (int i = 1; i <= DEB; i++) if (hist[i] == m_db) all_diff = 1'b0;
            new_db = all_diff ? !m_db : m_db;
            for (int d = 0; d < 2; d++) begin
                bit tmo;
                tmo = TMO && (m_wait[d] >= MW * SEC);
                m_s[d] = (state == 2'd2) ? (m_cnt[d] != 0) : ((m_cnt[d] >= TH) || tmo);
                if (state != 2'd2 && m_cnt[d] != 0)
                    m_wait[d] = (m_wait[d] < MW * SEC) ? m_wait[d] + 1 : m_wait[d];
                else
                    m_wait[d] = 0;
                if (m_evt) begin
                    if (state == 2'd2) m_cnt[d] = (m_cnt[d] > 0) ? m_cnt[d] - 1 : 0;
                    else               m_cnt[d] = (m_cnt[d] < cmax[d]) ? m_cnt[d] + 1 : cmax[d];
                end
            end
            m_evt  = m_rose;
            m_rose = new_db && !m_db;
            m_db   = new_db;
            for (int i = DEB; i >= 1; i--) hist[i] = hist[i-1];
            hist[0] = sensor;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("a_S",         int'(ifa.S),         int'(m_s[0]));
            chk("a_car_cnt",   int'(ifa.car_cnt),   m_cnt[0]);
            chk("a_sensor_db", int'(ifa.sensor_db), int'(m_db));
            chk("a_evt",       int'(ifa.evt),       int'(m_evt));
            chk("b_S",         int'(ifb.S),         int'(m_s[1]));
            chk("b_car_cnt",   int'(ifb.car_cnt),   m_cnt[1]);
            chk("b_evt",       int'(ifb.evt),       int'(m_evt));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse();
        sensor = 1'b1;
        cyc(8);
        sensor = 1'b0;
        cyc(8);
    endtask

    initial begin
        cyc(3);
        rst = 1'b1;
        sensor = 1'b1;
        cyc(3);
        rst = 1'b0;
        #1;
        chk("rst_S",         int'(ifa.S),         0);
        chk("rst_car_cnt",   int'(ifa.car_cnt),   0);
        chk("rst_sensor_db", int'(ifa.sensor_db), 0);
        chk("rst_evt",       int'(ifa.evt),       0);
        cyc(2);
        rst = 1'b1;
        sensor = 1'b0;
        cyc(10);
        chk("post_rst_db",  int'(ifa.sensor_db), 0);
        chk("post_rst_cnt", int'(ifa.car_cnt),   0);

        sensor = 1'b1;
        cyc(2);
        sensor = 1'b0;
        cyc(10);
        chk("glitch_db",  int'(ifa.sensor_db), 0);
        chk("glitch_cnt", int'(ifa.car_cnt),   0);

        pulse();
        chk("arr1_cnt", int'(ifa.car_cnt), 1);
        chk("arr1_S",   int'(ifa.S),       0);
        pulse();
        chk("arr2_cnt", int'(ifa.car_cnt), 2);
        chk("arr2_S",   int'(ifa.S),       1);

        state = 2'd2;
        pulse();
        chk("dep1_cnt", int'(ifa.car_cnt), 1);
        chk("dep1_S",   int'(ifa.S),       1);
        pulse();
        chk("dep2_cnt", int'(ifa.car_cnt), 0);
        chk("dep2_S",   int'(ifa.S),       0);
        pulse();
        chk("dep3_cnt", int'(ifa.car_cnt), 0);

        state = 2'd0;
        for (int p = 1; p <= 5; p++) begin
            pulse();
            if (p == 3) chk("sat3_b_cnt", int'(ifb.car_cnt), 3);
        end
        chk("sat5_b_cnt", int'(ifb.car_cnt), 3);
        chk("sat5_a_cnt", int'(ifa.car_cnt), 5);

        rst = 1'b0;
        cyc(2);
        rst = 1'b1;
        cyc(2);
        pulse();
        chk("tmo_cnt", int'(ifa.car_cnt), 1);
        cyc(15);
        chk("tmo_early_S", int'(ifa.S), 0);
        cyc(10);
        chk("tmo_late_S", int'(ifa.S), TMO ? 1 : 0);
        state = 2'd2;
        cyc(3);
        chk("tmo_cg_S", int'(ifa.S), 1);
        state = 2'd0;
        cyc(3);
        chk("tmo_clr_S",   int'(ifa.S),       0);
        chk("tmo_clr_cnt", int'(ifa.car_cnt), 1);
        cyc(35);
        chk("tmo_again_S", int'(ifa.S), TMO ? 1 : 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
